bram_pingpong_ctrl: RTL and testbench
=====================================

Name: bram_pingpong_ctrl

Overview:
- Ping-pong scheduler for the two 8-bit-write / 32-bit-read frame BRAMs.
- Streams bytes from the external-memory source into one bank while the other bank drains to the byte-select stage (sel 0..3 per 32-bit word).
- Replaces the free-running CM sequencing with a start/complete frame handshake and back-pressure on both sides.

Parameters:
- ADDRA_W, 11, write-port byte address width.
- ADDRB_W, 9, read-port word address width; must equal ADDRA_W-2.
- BANK_BYTES, 2048, bytes per bank fill; multiple of 4, at most 2**ADDRA_W.
- NUM_BLOCKS, 4, bank fills per frame; at least 1.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  frame start pulse.
- src_valid  in  1  source byte available.
- src_ready  out  1  controller accepts source byte.
- wea1  out  1  write strobe, bank 0.
- wea2  out  1  write strobe, bank 1.
- ena  out  1  write-port enable (wea1|wea2).
- addra  out  ADDRA_W  shared write byte address.
- enb1  out  1  read enable, bank 0.
- enb2  out  1  read enable, bank 1.
- addrb  out  ADDRB_W  shared read word address.
- rd_bank  out  1  bank currently drained (selects doutb1/doutb2 downstream).
- sel  out  2  byte lane select for the sm stage.
- out_valid  out  1  selected byte valid.
- out_ready  in  1  consumer accepts byte.
- busy  out  1  frame in progress.
- complete  out  1  one-cycle pulse at frame end.
- stall_cnt  out  16  see Optional Feature.

Behaviour:
- Reset: all outputs 0; full[1:0]=0; wbank=rbank=0; write and read counters 0; both FSMs idle. RESET mid-frame aborts immediately; no complete pulse. BRAM contents are don't-care.
- Frame: start while !busy sets busy next cycle and loads blk_wr=blk_rd=NUM_BLOCKS. start while busy is ignored.
- Write FSM states: W_IDLE, W_FILL, W_DONE.
  - W_IDLE goes to W_FILL on accepted start.
  - src_ready=1 in W_FILL when full[wbank]=0.
  - Write occurs on src_valid&&src_ready: wea(wbank+1)=1, addra=wr_cnt (registered counter, no latency), then wr_cnt++.
  - On wr_cnt==BANK_BYTES-1 accepted: full[wbank]<=1, wbank toggles, wr_cnt<=0, blk_wr--. If blk_wr was 1, go to W_DONE.
  - W_DONE goes to W_IDLE when the read side finishes.
- Read FSM states: R_IDLE, R_ISSUE, R_BEAT.
  - R_IDLE goes to R_ISSUE when busy and full[rbank].
  - R_ISSUE (1 cycle): enb(rbank+1)=1, addrb=rd_word. Then R_BEAT.
  - R_BEAT: out_valid=1, sel=beat, where beat starts at 0. doutb is valid this cycle (1-cycle BRAM latency) and holds because enb=0.
  - Beat accepted on out_valid&&out_ready: beat++. After beat 3 is accepted, rd_word++.
  - If rd_word was the last word (BANK_BYTES/4-1): full[rbank]<=0, rbank toggles, blk_rd--. Next state is R_IDLE, or frame end if blk_rd was 1.
  - Otherwise the next state is R_ISSUE.
  - Throughput is 4 bytes per 5 cycles with no stall.
- Byte order: byte address a maps to word a>>2, lane sel=a[1:0].
- Frame end: complete=1 for one cycle; busy<=0 in the same cycle; both FSMs go to idle.
- Simultaneous events:
  - Set and clear of full in the same cycle always target different banks, so both take effect.
  - Write never targets a full bank; read never targets a non-full bank.
  - When both banks are full: src_ready=0 until a drain completes.
  - When both banks are empty: the read FSM stays in R_IDLE.
- out_valid stays asserted with a stable sel until accepted.

Optional Feature:
- Macro: PINGPONG_STALL_CNT_EN.
- Defined: stall_cnt counts cycles with out_valid&&!out_ready. It saturates at 0xFFFF, clears on RESET and on accepted start, and holds after complete.
- Undefined: stall_cnt is tied to 0 and there is no counter logic.

Decomposition:
- Package img_ctrl_pkg holds:
  - ADDRA_W/ADDRB_W defaults and the BANK_WORDS derivation.
  - Write and read FSM state encodings.
  - The bank index type.
- Sub-module pp_bank_tracker holds full[1:0], wbank and rbank, with set/clear/toggle inputs. It is shared by both FSMs.

Test Plan:
- Reset/idle: RESET high 3 cycles, then low with no start → all outputs 0, src_ready=0, busy=0.
- Single block, BANK_BYTES=8, NUM_BLOCKS=1; source bytes 0x10..0x17 always valid, out_ready=1:
  - addra 0..7 with wea1 on each.
  - Then enb1 at addrb 0 and 1.
  - sel sequence 0,1,2,3,0,1,2,3.
  - complete pulses once, 1 cycle after the 8th beat.
- Ping-pong overlap, NUM_BLOCKS=4:
  - Bank1 filling while bank0 drains; rd_bank sequence 0,1,0,1.
  - wea2 and enb1 are asserted in the same cycle at least once.
- Back-pressure with out_ready=0 held:
  - After two fills src_ready=0; out_valid stays 1 with sel frozen.
  - stall_cnt increments each cycle when the macro is defined and stays 0 when it is not.
- Source gaps: src_valid toggling 1010 → addra advances only on accepted bytes; no skipped or duplicated addresses.
- Abort and restart:
  - RESET mid-drain: outputs drop to 0 next cycle and there is no complete pulse.
  - A new start then completes a full frame normally.
  - start during busy has no effect.

Source files
------------

// File: rtl/img_ctrl_pkg.sv
// Shared defaults, FSM encodings and bank index type for the frame BRAM ping-pong controller.
package img_ctrl_pkg;

    localparam int ADDRA_W_DEF    = 11;
    localparam int ADDRB_W_DEF    = ADDRA_W_DEF - 2;
    localparam int BANK_BYTES_DEF = 2048;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_DONE = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_BEAT  = 2'd2
    } rd_state_t;

    typedef logic bank_t;

    // Each 32-bit read word carries four write-side bytes.
    function automatic int bank_words(input int bank_bytes);
        return bank_bytes / 4;
    endfunction

endpackage

// File: rtl/pp_bank_tracker.sv
// Full flags and write/read bank pointers shared by the fill and drain FSMs.
module pp_bank_tracker
    import img_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       set_full,
    input  logic       clr_full,
    output logic [1:0] full,
    output bank_t      wbank,
    output bank_t      rbank
);

    // Set and clear always address different banks, so both updates land.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            full  <= '0;
            wbank <= 1'b0;
            rbank <= 1'b0;
        end else begin
            if (set_full) begin
                full[wbank] <= 1'b1;
                wbank       <= ~wbank;
            end
            if (clr_full) begin
                full[rbank] <= 1'b0;
                rbank       <= ~rbank;
            end
        end
    end

endmodule

// File: rtl/bram_pingpong_ctrl.sv
// Ping-pong fill/drain scheduler for two 8-bit-write / 32-bit-read frame BRAMs.
// Optional stall counter enabled by defining PINGPONG_STALL_CNT_EN.
module bram_pingpong_ctrl
    import img_ctrl_pkg::*;
#(
    parameter int ADDRA_W    = ADDRA_W_DEF,
    parameter int ADDRB_W    = ADDRB_W_DEF,
    parameter int BANK_BYTES = BANK_BYTES_DEF,
    parameter int NUM_BLOCKS = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               start,
    input  logic               src_valid,
    output logic               src_ready,
    output logic               wea1,
    output logic               wea2,
    output logic               ena,
    output logic [ADDRA_W-1:0] addra,
    output logic               enb1,
    output logic               enb2,
    output logic [ADDRB_W-1:0] addrb,
    output logic               rd_bank,
    output logic [1:0]         sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               complete,
    output logic [15:0]        stall_cnt
);

    localparam int BANK_WORDS = bank_words(BANK_BYTES);
    localparam int BLK_W      = $clog2(NUM_BLOCKS + 1);

    wr_state_t          wstate;
    rd_state_t          rstate;
    logic [ADDRA_W-1:0] wr_cnt;
    logic [ADDRB_W-1:0] rd_word;
    logic [1:0]         beat;
    logic [BLK_W-1:0]   blk_wr;
    logic [BLK_W-1:0]   blk_rd;
    logic [1:0]         full;
    bank_t              wbank;
    bank_t              rbank;

    logic start_acc, wr_fire, rd_fire, last_byte, last_word_beat, frame_end;

    pp_bank_tracker u_tracker (
        .CLK      (CLK),
        .RESET    (RESET),
        .set_full (last_byte),
        .clr_full (last_word_beat),
        .full     (full),
        .wbank    (wbank),
        .rbank    (rbank)
    );

    assign start_acc      = start && !busy;
    assign src_ready      = (wstate == W_FILL) && !full[wbank];
    assign wr_fire        = src_valid && src_ready;
    assign wea1           = wr_fire && (wbank == 1'b0);
    assign wea2           = wr_fire && (wbank == 1'b1);
    assign ena            = wr_fire;
    assign addra          = wr_cnt;
    assign last_byte      = wr_fire && (wr_cnt == ADDRA_W'(BANK_BYTES - 1));

    assign enb1           = (rstate == R_ISSUE) && (rbank == 1'b0);
    assign enb2           = (rstate == R_ISSUE) && (rbank == 1'b1);
    assign addrb          = rd_word;
    assign rd_bank        = rbank;
    assign out_valid      = (rstate == R_BEAT);
    assign sel            = beat;
    assign rd_fire        = out_valid && out_ready;
    assign last_word_beat = rd_fire && (beat == 2'd3) && (rd_word == ADDRB_W'(BANK_WORDS - 1));
    assign frame_end      = last_word_beat && (blk_rd == BLK_W'(1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wstate   <= W_IDLE;
            rstate   <= R_IDLE;
            busy     <= 1'b0;
            complete <= 1'b0;
            wr_cnt   <= '0;
            rd_word  <= '0;
            beat     <= '0;
            blk_wr   <= '0;
            blk_rd   <= '0;
        end else begin
            complete <= frame_end;

            if (start_acc) begin
                busy   <= 1'b1;
                blk_wr <= BLK_W'(NUM_BLOCKS);
                blk_rd <= BLK_W'(NUM_BLOCKS);
                wstate <= W_FILL;
            end

            if (wr_fire) begin
                if (last_byte) begin
                    wr_cnt <= '0;
                    blk_wr <= blk_wr - 1'b1;
                    if (blk_wr == BLK_W'(1))
                        wstate <= W_DONE;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end

            case (rstate)
                R_IDLE:  if (busy && full[rbank]) rstate <= R_ISSUE;
                R_ISSUE: rstate <= R_BEAT;
                R_BEAT: begin
                    if (rd_fire) begin
                        beat <= beat + 1'b1;
                        if (beat == 2'd3) begin
                            if (last_word_beat) begin
                                rd_word <= '0;
                                blk_rd  <= blk_rd - 1'b1;
                                rstate  <= R_IDLE;
                            end else begin
                                rd_word <= rd_word + 1'b1;
                                rstate  <= R_ISSUE;
                            end
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase

            // Frame end overrides everything above: both sides return to idle together.
            if (frame_end) begin
                busy   <= 1'b0;
                wstate <= W_IDLE;
                rstate <= R_IDLE;
            end
        end
    end

`ifdef PINGPONG_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge CLK) begin
        if (RESET)
            stall_q <= '0;
        else if (start_acc)
            stall_q <= '0;
        else if (out_valid && !out_ready && (stall_q != '1))
            stall_q <= stall_q + 1'b1;
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_bram_pingpong_ctrl.sv
// Scoreboard bench: a frame is a byte FIFO from source to consumer, with bank/address placement checked.
module tb_bram_pingpong_ctrl;

    localparam int AW = 11;
    localparam int BW = 9;
    localparam int BB = 8;
    localparam int NB = 4;
    localparam int FRAME_BYTES = BB * NB;

    logic          clk = 1'b0;
    logic          RESET, start, src_valid, out_ready;
    logic          src_ready, wea1, wea2, ena, enb1, enb2, rd_bank, out_valid, busy, complete;
    logic [AW-1:0] addra;
    logic [BW-1:0] addrb;
    logic [1:0]    sel;
    logic [15:0]   stall_cnt;
    logic [7:0]    src_byte;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [7:0]  q[$];
    logic [7:0]  mem[2][BB];
    logic [31:0] dout[2];
    int          wr_total = 0, rd_total = 0, rd_frame = 0, frames_done = 0;
    logic        busy_exp = 0, cmp_exp = 0, hold_pend = 0, rst_prev = 0, overlap = 0;
    logic [1:0]  hold_sel = '0;
    int          stall_exp = 0;

    bram_pingpong_ctrl #(
        .ADDRA_W    (AW),
        .ADDRB_W    (BW),
        .BANK_BYTES (BB),
        .NUM_BLOCKS (NB)
    ) dut (
        .CLK       (clk),
        .RESET     (RESET),
        .start     (start),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .wea1      (wea1),
        .wea2      (wea2),
        .ena       (ena),
        .addra     (addra),
        .enb1      (enb1),
        .enb2      (enb2),
        .addrb     (addrb),
        .rd_bank   (rd_bank),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .complete  (complete),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard at the falling edge, where every handshake for the next rising edge is settled.
    always @(negedge clk) begin
        logic fire_w, acc, start_acc;
        int   b, w, s;
        logic [7:0] e;
        if (rst_prev)
            chk("reset_zero", {src_ready, wea1, wea2, ena, enb1, enb2, addra, addrb, rd_bank,
                               sel, out_valid, busy, complete, stall_cnt}, 64'd0);
        if (RESET) begin
            q.delete();
            wr_total = 0; rd_total = 0; rd_frame = 0;
            busy_exp = 0; cmp_exp = 0; stall_exp = 0; hold_pend = 0;
        end else begin
            chk("busy", busy, busy_exp);
            chk("complete", complete, cmp_exp);
`ifdef PINGPONG_STALL_CNT_EN
            chk("stall_cnt", stall_cnt, stall_exp);
`else
            chk("stall_cnt", stall_cnt, 0);
`endif
            fire_w = src_valid && src_ready;
            b = (wr_total / BB) % 2;
            chk("wea", {wea2, wea1}, fire_w ? (b == 1 ? 2'b10 : 2'b01) : 2'b00);
            chk("ena", ena, fire_w);
            if (fire_w) begin
                chk("addra", addra, wr_total % BB);
                mem[b][wr_total % BB] = src_byte;
                q.push_back(src_byte);
                wr_total++;
            end
            if (enb1 || enb2) begin
                b = (rd_total / BB) % 2;
                w = (rd_total % BB) / 4;
                chk("enb", {enb2, enb1}, b == 1 ? 2'b10 : 2'b01);
                chk("addrb", addrb, w);
                dout[b] = {mem[b][4*w+3], mem[b][4*w+2], mem[b][4*w+1], mem[b][4*w]};
            end
            if (wea2 && enb1) overlap = 1;
            if (hold_pend) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_sel", sel, hold_sel);
            end
            hold_pend = out_valid && !out_ready;
            hold_sel  = sel;

            acc = out_valid && out_ready;
            start_acc = start && !busy_exp;
            cmp_exp = 0;
            if (acc) begin
                chk("sel", sel, rd_total % 4);
                chk("rd_bank", rd_bank, (rd_total / BB) % 2);
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL data_underflow actual=beat required=no_beat at %0t", $time);
                end else begin
                    e = q.pop_front();
                    s = sel;
                    chk("data", dout[rd_bank][8*s +: 8], e);
                end
                rd_total++;
                rd_frame++;
                if (rd_frame == FRAME_BYTES) begin
                    cmp_exp = 1;
                    busy_exp = 0;
                    rd_frame = 0;
                    frames_done++;
                end
            end
            if (out_valid && !out_ready && stall_exp != 16'hFFFF) stall_exp++;
            if (start_acc) begin
                busy_exp = 1;
                stall_exp = 0;
            end
        end
        rst_prev = RESET;
    end

    // mode 0: free flow, 1: random with a start while busy, 2: consumer stalled, 3: source gaps 1010
    task automatic run_frame(input int mode);
        int f0, w0, n;
        f0 = frames_done; w0 = wr_total; n = 0;
        @(posedge clk); #1;
        start = 1'b1;
        while (frames_done == f0 && n < 2000) begin
            @(posedge clk); #1;
            start = (mode == 1 && n == 20);
            case (mode)
                0: begin src_valid = 1'b1; out_ready = 1'b1; end
                1: begin
                    src_valid = 1'($urandom_range(0, 1));
                    out_ready = 1'($urandom_range(0, 1));
                end
                2: begin
                    if (n == 40) begin
                        chk("bp_src_ready", src_ready, 1'b0);
                        chk("bp_out_valid", out_valid, 1'b1);
                        chk("bp_fill_bytes", wr_total - w0, 2 * BB);
                    end
                    src_valid = 1'b1;
                    out_ready = (n >= 40);
                end
                default: begin src_valid = (n % 2 == 0); out_ready = 1'b1; end
            endcase
            src_byte = 8'($urandom);
            n++;
        end
        chk("frame_done", frames_done != f0, 1'b1);
        start = 1'b0; src_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic abort_frame();
        int n;
        n = 0;
        @(posedge clk); #1;
        start = 1'b1;
        while (rd_frame < 12 && n < 2000) begin
            @(posedge clk); #1;
            start = 1'b0;
            src_valid = 1'($urandom_range(0, 1));
            out_ready = 1'b1;
            src_byte = 8'($urandom);
            n++;
        end
        chk("abort_reached_drain", rd_frame >= 12, 1'b1);
        RESET = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        RESET = 1'b0; src_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        RESET = 1'b1; start = 1'b0; src_valid = 1'b0; out_ready = 1'b0; src_byte = '0;
        repeat (3) @(posedge clk);
        #1 RESET = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        run_frame(0);
        run_frame(1);
        run_frame(2);
        run_frame(3);
        abort_frame();
        run_frame(1);
        chk("overlap_seen", overlap, 1'b1);
        chk("queue_empty", q.size(), 0);
        chk("frames_total", frames_done, 5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
